data_h_input_conditioner: RTL and testbench

Upstream conditioner for the 4-bit DATA_H parallel input port. Takes raw, asynchronous board-level signals, synchronises and debounces each bit, and drives the settled value into the PIO's `in_port`. It also keeps sticky per-bit edge flags and raises a maskable interrupt request, so software need not poll for transitions.

---
 rtl/data_h_pkg.sv | 20 ++
 rtl/data_h_debounce_bit.sv | 71 +++++++
 rtl/data_h_input_conditioner.sv | 71 +++++++
 tb/tb_data_h_input_conditioner.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_h_pkg.sv
// ---------------------------------------------------------------------------
// data_h_pkg
// Shared definitions for the DATA_H input conditioner.
//   EDGE_RISE / EDGE_FALL / EDGE_BOTH : values of the EDGE_MODE parameter.
//   cnt_width()                       : debounce counter width for a given
//                                       DEBOUNCE_CYCLES, never below 1 bit.
// ---------------------------------------------------------------------------
package data_h_pkg;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_BOTH = 2;

   // The counter only has to reach DEBOUNCE_CYCLES-1, so clog2 suffices;
   // DEBOUNCE_CYCLES=1 would give a zero-width counter, hence the floor.
   function automatic int cnt_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/data_h_debounce_bit.sv
// ---------------------------------------------------------------------------
// data_h_debounce_bit
// One input bit: 2-flop synchroniser, debounce counter and settled level.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   raw_in       : raw pin, asynchronous to clk
//   data_out     : debounced level
//   rise, fall   : single-cycle pulses, high in the cycle whose closing
//                  edge moves data_out 0->1 (rise) or 1->0 (fall)
// ---------------------------------------------------------------------------
module data_h_debounce_bit
   import data_h_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw_in,
   output logic data_out,
   output logic rise,
   output logic fall
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q;
   logic          s2_q;
   logic          level_q;
   logic          level_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour (s1 -> s2 must not collapse).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         s1_q    <= raw_in;
         s2_q    <= s1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   // NOTE: defaults first, so every path assigns every output and no latch
   // is inferred. A matching s2 (glitch returned) falls through to cnt_d=0.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (s2_q != level_q) begin
         // Terminal count is consumed by the update, so the counter never wraps.
         if (cnt_q == CNT_LAST) begin
            level_d = s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign data_out = level_q;
   // Pulses are taken from next-state so a flag register sampling them
   // sets on the very edge that updates data_out.
   assign rise     = level_d & ~level_q;
   assign fall     = ~level_d & level_q;

endmodule

// File: rtl/data_h_input_conditioner.sv
// ---------------------------------------------------------------------------
// data_h_input_conditioner
// Conditions the DATA_H parallel port: per-bit synchronise + debounce, sticky
// edge flags and a maskable interrupt request.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   raw_in       : raw pins (WIDTH), asynchronous to clk
//   edge_clr     : per-bit flag clear, level-sensitive
//   irq_mask     : per-bit interrupt enable
//   data_out     : debounced levels, to PIO in_port
//   edge_flags   : sticky edge-capture flags
//   irq          : |(edge_flags & irq_mask), combinational
// ---------------------------------------------------------------------------
module data_h_input_conditioner
   import data_h_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_MODE       = EDGE_BOTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] raw_in,
   input  logic [WIDTH-1:0] edge_clr,
   input  logic [WIDTH-1:0] irq_mask,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] edge_flags,
   output logic             irq
);

   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] ev;
   logic [WIDTH-1:0] flags_q;
   logic [WIDTH-1:0] flags_d;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      data_h_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
         .clk     (clk),
         .reset_n (reset_n),
         .raw_in  (raw_in[i]),
         .data_out(data_out[i]),
         .rise    (rise[i]),
         .fall    (fall[i])
      );
   end

   always_comb begin
      case (EDGE_MODE)
         EDGE_RISE: ev = rise;
         EDGE_FALL: ev = fall;
         default:   ev = rise | fall;
      endcase
      // Event is OR-ed in after the clear, so a same-cycle set wins.
      flags_d = (flags_q & ~edge_clr) | ev;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign edge_flags = flags_q;
   assign irq        = |(flags_q & irq_mask);

endmodule

// File: tb/tb_data_h_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_data_h_input_conditioner
// Two instances share stimulus: EDGE_MODE=2 (both edges) and EDGE_MODE=1
// (falling only), DEBOUNCE_CYCLES=8. Directed scenarios plus a random phase;
// a sliding-window reference model is compared on every cycle.
// ---------------------------------------------------------------------------
module tb_data_h_input_conditioner;

   localparam int W = 4;
   localparam int D = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] raw_in = '0;
   logic [W-1:0] edge_clr = '0;
   logic [W-1:0] irq_mask = '0;

   logic [W-1:0] dout2, flags2, dout1, flags1;
   logic         irq2, irq1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   data_h_input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2)) dut_both (
      .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .edge_clr(edge_clr),
      .irq_mask(irq_mask), .data_out(dout2), .edge_flags(flags2), .irq(irq2)
   );

   data_h_input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(1)) dut_fall (
      .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .edge_clr(edge_clr),
      .irq_mask(irq_mask), .data_out(dout1), .edge_flags(flags1), .irq(irq1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // hist holds the raw value sampled at each edge since reset (zeros stand
   // for the cleared synchroniser). At edge t the synchronised value seen is
   // the sample from edge t-2; the level flips when the last D such values
   // all differ from the current level.
   logic [W-1:0] hist[$];
   logic [W-1:0] m_dout   = '0;
   logic [W-1:0] m_flags2 = '0;
   logic [W-1:0] m_flags1 = '0;
   logic [W-1:0] m_next, m_rise, m_fall;
   bit           all_diff;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_dout   = '0;
         m_flags2 = '0;
         m_flags1 = '0;
         hist.delete();
         for (int k = 0; k < D + 1; k++) hist.push_back('0);
      end else begin
         m_next = m_dout;
         for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int k = 2; k <= D + 1; k++)
               if (hist[hist.size() - k][b] == m_dout[b]) all_diff = 1'b0;
            if (all_diff) m_next[b] = ~m_dout[b];
         end
         m_rise   = m_next & ~m_dout;
         m_fall   = ~m_next & m_dout;
         m_flags2 = (m_flags2 & ~edge_clr) | m_rise | m_fall;
         m_flags1 = (m_flags1 & ~edge_clr) | m_fall;
         m_dout   = m_next;
         hist.push_back(raw_in);
         while (hist.size() > D + 2) void'(hist.pop_front());
      end
   end

   // Cycle-by-cycle comparison, 1 time unit after the falling edge.
   always @(negedge clk) begin
      #1;
      check("model_dout_both",  32'(dout2),  32'(m_dout));
      check("model_flags_both", 32'(flags2), 32'(m_flags2));
      check("model_irq_both",   32'(irq2),   32'(|(m_flags2 & irq_mask)));
      check("model_dout_fall",  32'(dout1),  32'(m_dout));
      check("model_flags_fall", 32'(flags1), 32'(m_flags1));
      check("model_irq_fall",   32'(irq1),   32'(|(m_flags1 & irq_mask)));
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leaves the bench at a falling edge with reset just released; the next
   // rising edge is the first to sample raw_in.
   task automatic do_reset(input logic [W-1:0] raw);
      @(negedge clk);
      reset_n  = 1'b0;
      raw_in   = raw;
      edge_clr = '0;
      irq_mask = '0;
      cyc(2);
      reset_n = 1'b1;
   endtask

   initial begin
      // ---- reset with all pins high ----
      @(negedge clk);
      reset_n = 1'b0;
      raw_in  = 4'hF;
      cyc(3);
      #1;
      check("rst_dout",  32'(dout2),  32'h0);
      check("rst_flags", 32'(flags2), 32'h0);
      check("rst_irq",   32'(irq2),   32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(9);
      #1 check("rst_dout_edge8", 32'(dout2), 32'h0);
      cyc(1);
      #1;
      check("rst_dout_edge9",  32'(dout2),  32'hF);
      check("rst_flags_edge9", 32'(flags2), 32'hF);

      // ---- glitch rejection ----
      do_reset('0);
      cyc(10);
      raw_in[0] = 1'b1;
      cyc(7);
      raw_in[0] = 1'b0;
      cyc(15);
      #1;
      check("glitch7_dout",  32'(dout2[0]),  32'h0);
      check("glitch7_flags", 32'(flags2[0]), 32'h0);
      @(negedge clk);
      raw_in[0] = 1'b1;
      cyc(9);
      raw_in[0] = 1'b0;
      #1 check("pulse9_edge8", 32'(dout2[0]), 32'h0);
      cyc(1);
      #1 check("pulse9_edge9", 32'(dout2[0]), 32'h1);

      // ---- falling-only edge mode ----
      do_reset('0);
      cyc(5);
      raw_in[2] = 1'b1;
      cyc(20);
      #1;
      check("mode1_after_rise_dout",  32'(dout1[2]),  32'h1);
      check("mode1_after_rise_flag",  32'(flags1[2]), 32'h0);
      check("mode2_after_rise_flag",  32'(flags2[2]), 32'h1);
      @(negedge clk);
      raw_in[2] = 1'b0;
      cyc(20);
      #1;
      check("mode1_after_fall_dout", 32'(dout1[2]),  32'h0);
      check("mode1_after_fall_flag", 32'(flags1[2]), 32'h1);

      // ---- clear racing a new fall ----
      do_reset('0);
      raw_in[1] = 1'b1;
      cyc(20);
      #1 check("race_rise_flag", 32'(flags2[1]), 32'h1);
      @(negedge clk);
      raw_in[1] = 1'b0;
      cyc(9);
      edge_clr[1] = 1'b1;      // active for the edge that carries the fall
      cyc(1);
      edge_clr[1] = 1'b0;
      #1;
      check("race_dout",      32'(dout2[1]),  32'h0);
      check("race_flag_kept", 32'(flags2[1]), 32'h1);
      @(negedge clk);
      edge_clr[1] = 1'b1;
      cyc(1);
      edge_clr[1] = 1'b0;
      #1 check("clr_alone_flag", 32'(flags2[1]), 32'h0);

      // ---- interrupt masking ----
      do_reset('0);
      raw_in = 4'b0101;
      cyc(15);
      irq_mask = 4'b1010;
      #1;
      check("irq_flags",  32'(flags2), 32'h5);
      check("irq_masked", 32'(irq2),   32'h0);
      #1 irq_mask = 4'b0100;
      #1 check("irq_unmasked_same_cycle", 32'(irq2), 32'h1);

      // ---- reset in the middle of a count ----
      do_reset('0);
      cyc(3);
      raw_in[3] = 1'b1;
      cyc(7);                   // edges 0..6 sampled: counter at 5
      reset_n = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      cyc(9);
      #1 check("midrst_edge8", 32'(dout2[3]), 32'h0);
      cyc(1);
      #1 check("midrst_edge9", 32'(dout2[3]), 32'h1);

      // ---- random phase, checked by the model ----
      do_reset(4'($urandom));
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         for (int b = 0; b < W; b++)
            if ($urandom_range(0, (c < 400) ? 5 : 11) == 0) raw_in[b] = ~raw_in[b];
         edge_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
         if ($urandom_range(0, 15) == 0) irq_mask = 4'($urandom);
         if (c == 500) reset_n = 1'b0;
         if (c == 503) reset_n = 1'b1;
      end
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
